// File: rtl/dma_resp_mem.sv
// -----------------------------------------------------------------------------
// dma_resp_mem
//
// A 16-bit-wide DMA target memory with configurable wait states. Each request
// is held by the initiator until dma_ready is seen. The transfer takes N
// wait-state cycles and then completes in a one-cycle ACK, where read data and
// the error response are presented. All outputs are registered.
//
// Parameters
//   DEPTH       number of 16-bit words (power of two, 2..4096)
//   BASE_ADDR   byte address of word 0 (bit 0 ignored)
//   WAIT_STATES wait-state count N, 0..15
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   dma_addr   in   [15:0] byte address of the transfer
//   dma_en     in   request valid, held until dma_ready
//   dma_wen    in   [1:0] byte write enables ([0]=low, [1]=high), 2'b00 = read
//   dma_din    in   [15:0] write data
//   dma_ready  out  transfer completes this cycle
//   dma_dout   out  [15:0] read data, valid only with dma_ready
//   dma_resp   out  error response, valid only with dma_ready
//
// Configuration macro
//   DMA_RESP_ERR_EN  defined  : out-of-range accesses complete with
//                               dma_resp=1, read data 0, writes dropped.
//                    undefined: dma_resp tied low, the word index aliases
//                               modulo DEPTH.
// -----------------------------------------------------------------------------
module dma_resp_mem #(
    parameter int          DEPTH       = 64,
    parameter logic [15:0] BASE_ADDR   = 16'h0200,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dma_addr,
    input  logic        dma_en,
    input  logic [1:0]  dma_wen,
    input  logic [15:0] dma_din,
    output logic        dma_ready,
    output logic [15:0] dma_dout,
    output logic        dma_resp
);

    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  N_WS    = 4'(WAIT_STATES);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        ready_q, ready_d;
    logic        resp_q,  resp_d;
    logic [15:0] dout_q,  dout_d;

    // Memory array; deliberately not touched by reset.
    logic [15:0] mem [DEPTH];

    // Address decode. The subtraction is 15-bit so an address below BASE_ADDR
    // wraps to a large index and falls out of range.
    logic [14:0]   idx15;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          acc_err;
    logic          is_read;
    logic          go_ack;
    logic          mem_we;

    assign idx15    = dma_addr[15:1] - BASE_ADDR[15:1];
    assign idx      = idx15[AW-1:0];
    assign in_range = ({1'b0, idx15} < DEPTH_W);
    assign is_read  = (dma_wen == 2'b00);

`ifdef DMA_RESP_ERR_EN
    assign acc_err = ~in_range;
`else
    // Aliasing mode: the low index bits select the word, nothing errors.
    assign acc_err = 1'b0;
`endif

    // Address bit 0 and (in aliasing mode) the upper index bits are unused.
    logic unused_bits;
    assign unused_bits = ^{dma_addr[0], idx15, in_range};

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = 1'b0;
        resp_d  = 1'b0;
        dout_d  = 16'h0000;
        go_ack  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (dma_en) begin
                    if (N_WS == 4'd0) begin
                        go_ack = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = N_WS - 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                // Initiator withdrawing the request abandons the transfer.
                if (!dma_en) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    go_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                // One-cycle completion; the still-held dma_en is ignored here.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Entering ACK: the access uses the inputs sampled at this edge.
        if (go_ack) begin
            state_d = ST_ACK;
            cnt_d   = 4'd0;
            ready_d = 1'b1;
            resp_d  = acc_err;
            dout_d  = (is_read && !acc_err) ? mem[idx] : 16'h0000;
        end
    end

    // -------------------------------------------------------------------------
    // Control and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
            resp_q  <= 1'b0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
            dout_q  <= dout_d;
        end
    end

    // reset_n gates the write so an edge seen while reset is held (possible
    // with zero wait states and dma_en high) cannot modify memory.
    assign mem_we = go_ack & ~is_read & ~acc_err & reset_n;

    // -------------------------------------------------------------------------
    // Memory write port with byte enables
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (dma_wen[0]) begin
                mem[idx][7:0] <= dma_din[7:0];
            end
            if (dma_wen[1]) begin
                mem[idx][15:8] <= dma_din[15:8];
            end
        end
    end

    assign dma_ready = ready_q;
    assign dma_resp  = resp_q;
    assign dma_dout  = dout_q;

endmodule
